// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the 16-bit RISC core.
// Emits datapath enables, handshakes with memories and MUL/DIV, counts retired instructions.
module cpu_sequencer #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             alu_done,
    input  logic             halt_req,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             alu_start,
    output logic             wb_en,
    output logic             pc_en,
    output logic             halted,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6,
        StErr    = 3'd7
    } state_e;

    localparam logic [3:0] OpNop = 4'b0000;
    localparam logic [3:0] OpMul = 4'b0011;
    localparam logic [3:0] OpDiv = 4'b0110;
    localparam logic [3:0] OpJal = 4'b0111;
    localparam logic [3:0] OpJ   = 4'b1010;
    localparam logic [3:0] OpJr  = 4'b1011;
    localparam logic [3:0] OpLw  = 4'b1100;
    localparam logic [3:0] OpSw  = 4'b1101;

    localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] count_q;
    logic             waiting;
    logic             timed_out;
    logic             is_muldiv;
    logic             exec_first;
    state_e           boundary_st;

    assign is_muldiv   = (opcode == OpMul) || (opcode == OpDiv);
    // The wait counter is cleared on entry and bumps every EXEC cycle, so zero marks the first.
    assign exec_first  = (wait_q == 8'd0);
    assign timed_out   = (wait_q >= TimeoutVal);
    assign boundary_st = halt_req ? StHalt : StFetch;

    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        alu_start = 1'b0;
        wb_en     = 1'b0;
        pc_en     = 1'b0;
        halted    = 1'b0;
        err       = 1'b0;
        waiting   = 1'b0;

        unique case (state_q)
            StIdle: state_d = halt_req ? StHalt : StFetch;
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = StDecode;
                end else begin
                    waiting = 1'b1;
                    if (timed_out) state_d = StErr;
                end
            end
            StDecode: begin
                case (opcode)
                    OpNop, OpJ, OpJr: begin
                        pc_en   = 1'b1;
                        state_d = boundary_st;
                    end
                    OpJal: begin
                        pc_en   = 1'b1;
                        wb_en   = 1'b1;
                        state_d = boundary_st;
                    end
                    default: state_d = StExec;
                endcase
            end
            StExec: begin
                if (is_muldiv) begin
                    if (exec_first) begin
                        alu_start = 1'b1;
                        waiting   = 1'b1;
                    end else if (alu_done) begin
                        state_d = StWb;
                    end else begin
                        waiting = 1'b1;
                        if (timed_out) state_d = StErr;
                    end
                end else if ((opcode == OpLw) || (opcode == OpSw)) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OpSw);
                if (dmem_ready) begin
                    if (opcode == OpSw) begin
                        pc_en   = 1'b1;
                        state_d = boundary_st;
                    end else begin
                        state_d = StWb;
                    end
                end else begin
                    waiting = 1'b1;
                    if (timed_out) state_d = StErr;
                end
            end
            StWb: begin
                wb_en   = 1'b1;
                pc_en   = 1'b1;
                state_d = boundary_st;
            end
            StHalt: begin
                halted = 1'b1;
                if (!halt_req) state_d = StFetch;
            end
            StErr: err = 1'b1;
            default: state_d = StErr;
        endcase

        if (state_d != state_q) begin
            wait_d = 8'd0;
        end else if (waiting) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wait_q  <= 8'd0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (pc_en) count_q <= count_q + CNT_W'(1);
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: per-cycle expected state/outputs are queued
// alongside the stimulus and compared as each cycle is run.
module tb_cpu_sequencer;

    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned CNT_W   = 8;

    localparam logic [3:0] OpNop = 4'b0000;
    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpMul = 4'b0011;
    localparam logic [3:0] OpDiv = 4'b0110;
    localparam logic [3:0] OpJal = 4'b0111;
    localparam logic [3:0] OpJ   = 4'b1010;
    localparam logic [3:0] OpJr  = 4'b1011;
    localparam logic [3:0] OpLw  = 4'b1100;
    localparam logic [3:0] OpSw  = 4'b1101;

    localparam logic [2:0] SIdle = 3'd0, SFetch = 3'd1, SDec = 3'd2, SExec = 3'd3;
    localparam logic [2:0] SMem  = 3'd4, SWb    = 3'd5, SHalt = 3'd6, SErr = 3'd7;

    // Stimulus control bits: {rst, halt_req, alu_done, dmem_ready, imem_ready}
    localparam logic [4:0] CNone = 5'b00000, CImem = 5'b00001, CDrdy = 5'b00010;
    localparam logic [4:0] CAdone = 5'b00100, CHalt = 5'b01000, CRst = 5'b10000;

    // Output flags: {imem_req, ir_load, dmem_req, dmem_we, alu_start, wb_en, pc_en, halted, err}
    localparam logic [8:0] FNone = 9'h000, FImem = 9'h100, FIrld = 9'h080, FDreq = 9'h040;
    localparam logic [8:0] FWe = 9'h020, FAlus = 9'h010, FWb = 9'h008, FPc = 9'h004;
    localparam logic [8:0] FHalt = 9'h002, FErr = 9'h001;

    typedef struct packed {
        logic [4:0] ctl;
        logic [3:0] op;
    } stim_t;

    typedef struct packed {
        stim_t       stim;
        logic [11:0] obs;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic imem_ready = 1'b0, dmem_ready = 1'b0, alu_done = 1'b0, halt_req = 1'b0;
    logic imem_req, ir_load, dmem_req, dmem_we, alu_start, wb_en, pc_en, halted, err;
    logic [2:0] state;
    logic [CNT_W-1:0] instr_count;

    entry_t sb_q[$];
    int checks = 0;
    int passed = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    cpu_sequencer #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .alu_done   (alu_done),
        .halt_req   (halt_req),
        .imem_req   (imem_req),
        .ir_load    (ir_load),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .alu_start  (alu_start),
        .wb_en      (wb_en),
        .pc_en      (pc_en),
        .halted     (halted),
        .err        (err),
        .state      (state),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Queue one cycle of stimulus with its expected state and outputs; track the retire count.
    task automatic push(input logic [3:0] op, input logic [4:0] ctl, input logic [2:0] s,
                        input logic [8:0] f);
        entry_t e;
        e.stim.ctl = ctl;
        e.stim.op  = op;
        e.obs      = {s, f};
        sb_q.push_back(e);
        if (ctl[4]) exp_cnt = '0;
        else if (f[2]) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic drive_sample(input stim_t s, output logic [11:0] o);
        {rst, halt_req, alu_done, dmem_ready, imem_ready} = s.ctl;
        opcode = s.op;
        @(negedge clk);
        o = {state, imem_req, ir_load, dmem_req, dmem_we, alu_start, wb_en, pc_en, halted, err};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        entry_t e;
        logic [11:0] o;
        int n = 0;
        @(posedge clk);
        #1;
        push(OpNop, CRst, SIdle, FNone);
        push(OpNop, CRst, SIdle, FNone);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            drive_sample(e.stim, o);
            checks++;
            if (o !== e.obs) $display("FAIL reset cyc %0d: got %h want %h", n, o, e.obs);
            else passed++;
            n++;
        end
        checks++;
        if (instr_count !== exp_cnt)
            $display("FAIL reset count: got %0d want %0d", instr_count, exp_cnt);
        else passed++;
    endtask

    task automatic test_alu();
        entry_t e;
        logic [11:0] o;
        int n = 0;
        push(OpAdd, CNone, SIdle, FNone);
        push(OpAdd, CImem, SFetch, FImem | FIrld);
        push(OpAdd, CNone, SDec, FNone);
        push(OpAdd, CNone, SExec, FNone);
        push(OpAdd, CNone, SWb, FWb | FPc);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            drive_sample(e.stim, o);
            checks++;
            if (o !== e.obs) $display("FAIL alu cyc %0d: got %h want %h", n, o, e.obs);
            else passed++;
            n++;
        end
        checks++;
        if (instr_count !== exp_cnt)
            $display("FAIL alu count: got %0d want %0d", instr_count, exp_cnt);
        else passed++;
    endtask

    task automatic test_mem();
        entry_t e;
        logic [11:0] o;
        int n = 0;
        push(OpLw, CImem, SFetch, FImem | FIrld);
        push(OpLw, CNone, SDec, FNone);
        push(OpLw, CNone, SExec, FNone);
        for (int i = 0; i < 3; i++) push(OpLw, CNone, SMem, FDreq);
        push(OpLw, CDrdy, SMem, FDreq);
        push(OpLw, CNone, SWb, FWb | FPc);
        push(OpSw, CImem, SFetch, FImem | FIrld);
        push(OpSw, CNone, SDec, FNone);
        push(OpSw, CNone, SExec, FNone);
        push(OpSw, CDrdy, SMem, FDreq | FWe | FPc);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            drive_sample(e.stim, o);
            checks++;
            if (o !== e.obs) $display("FAIL mem cyc %0d: got %h want %h", n, o, e.obs);
            else passed++;
            n++;
        end
        checks++;
        if (instr_count !== exp_cnt)
            $display("FAIL mem count: got %0d want %0d", instr_count, exp_cnt);
        else passed++;
    endtask

    task automatic test_muldiv();
        entry_t e;
        logic [11:0] o;
        int n = 0;
        push(OpDiv, CImem, SFetch, FImem | FIrld);
        push(OpDiv, CNone, SDec, FNone);
        push(OpDiv, CAdone, SExec, FAlus);
        for (int i = 0; i < 4; i++) push(OpDiv, CNone, SExec, FNone);
        push(OpDiv, CAdone, SExec, FNone);
        push(OpDiv, CNone, SWb, FWb | FPc);
        push(OpMul, CImem, SFetch, FImem | FIrld);
        push(OpMul, CNone, SDec, FNone);
        push(OpMul, CAdone, SExec, FAlus);
        push(OpMul, CAdone, SExec, FNone);
        push(OpMul, CNone, SWb, FWb | FPc);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            drive_sample(e.stim, o);
            checks++;
            if (o !== e.obs) $display("FAIL muldiv cyc %0d: got %h want %h", n, o, e.obs);
            else passed++;
            n++;
        end
        checks++;
        if (instr_count !== exp_cnt)
            $display("FAIL muldiv count: got %0d want %0d", instr_count, exp_cnt);
        else passed++;
    endtask

    task automatic test_jump();
        entry_t e;
        logic [11:0] o;
        int n = 0;
        push(OpJal, CImem, SFetch, FImem | FIrld);
        push(OpJal, CNone, SDec, FPc | FWb);
        push(OpJ, CImem, SFetch, FImem | FIrld);
        push(OpJ, CNone, SDec, FPc);
        push(OpJr, CImem, SFetch, FImem | FIrld);
        push(OpJr, CNone, SDec, FPc);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            drive_sample(e.stim, o);
            checks++;
            if (o !== e.obs) $display("FAIL jump cyc %0d: got %h want %h", n, o, e.obs);
            else passed++;
            n++;
        end
        checks++;
        if (instr_count !== exp_cnt)
            $display("FAIL jump count: got %0d want %0d", instr_count, exp_cnt);
        else passed++;
    endtask

    task automatic test_halt();
        entry_t e;
        logic [11:0] o;
        int n = 0;
        push(OpLw, CImem, SFetch, FImem | FIrld);
        push(OpLw, CHalt, SDec, FNone);
        push(OpLw, CHalt, SExec, FNone);
        push(OpLw, CHalt | CDrdy, SMem, FDreq);
        push(OpLw, CHalt, SWb, FWb | FPc);
        push(OpLw, CHalt, SHalt, FHalt);
        push(OpLw, CHalt, SHalt, FHalt);
        push(OpLw, CNone, SHalt, FHalt);
        push(OpNop, CImem, SFetch, FImem | FIrld);
        push(OpNop, CNone, SDec, FPc);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            drive_sample(e.stim, o);
            checks++;
            if (o !== e.obs) $display("FAIL halt cyc %0d: got %h want %h", n, o, e.obs);
            else passed++;
            n++;
        end
        checks++;
        if (instr_count !== exp_cnt)
            $display("FAIL halt count: got %0d want %0d", instr_count, exp_cnt);
        else passed++;
    endtask

    task automatic test_timeout_edge();
        entry_t e;
        logic [11:0] o;
        int n = 0;
        for (int i = 0; i < TIMEOUT; i++) push(OpNop, CNone, SFetch, FImem);
        push(OpNop, CImem, SFetch, FImem | FIrld);
        push(OpNop, CNone, SDec, FPc);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            drive_sample(e.stim, o);
            checks++;
            if (o !== e.obs) $display("FAIL tmo_edge cyc %0d: got %h want %h", n, o, e.obs);
            else passed++;
            n++;
        end
        checks++;
        if (instr_count !== exp_cnt)
            $display("FAIL tmo_edge count: got %0d want %0d", instr_count, exp_cnt);
        else passed++;
    endtask

    task automatic test_timeout_err();
        entry_t e;
        logic [11:0] o;
        int n = 0;
        for (int i = 0; i <= TIMEOUT; i++) push(OpNop, CNone, SFetch, FImem);
        for (int i = 0; i < 3; i++) push(OpNop, CImem | CDrdy | CAdone, SErr, FErr);
        push(OpNop, CRst, SErr, FErr);
        push(OpNop, CNone, SIdle, FNone);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            drive_sample(e.stim, o);
            checks++;
            if (o !== e.obs) $display("FAIL tmo_err cyc %0d: got %h want %h", n, o, e.obs);
            else passed++;
            n++;
        end
        checks++;
        if (instr_count !== exp_cnt)
            $display("FAIL tmo_err count: got %0d want %0d", instr_count, exp_cnt);
        else passed++;
    endtask

    task automatic test_wrap();
        entry_t e;
        logic [11:0] o;
        int n = 0;
        for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
            push(OpNop, CImem, SFetch, FImem | FIrld);
            push(OpNop, CNone, SDec, FPc);
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            drive_sample(e.stim, o);
            checks++;
            if (o !== e.obs) $display("FAIL wrap cyc %0d: got %h want %h", n, o, e.obs);
            else passed++;
            n++;
        end
        checks++;
        if (instr_count !== exp_cnt)
            $display("FAIL wrap max count: got %0d want %0d", instr_count, exp_cnt);
        else passed++;
        push(OpNop, CImem, SFetch, FImem | FIrld);
        push(OpNop, CNone, SDec, FPc);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            drive_sample(e.stim, o);
            checks++;
            if (o !== e.obs) $display("FAIL wrap last cyc %0d: got %h want %h", n, o, e.obs);
            else passed++;
            n++;
        end
        checks++;
        if (instr_count !== exp_cnt)
            $display("FAIL wrap zero count: got %0d want %0d", instr_count, exp_cnt);
        else passed++;
    endtask

    task automatic test_rst_mem();
        entry_t e;
        logic [11:0] o;
        int n = 0;
        push(OpLw, CImem, SFetch, FImem | FIrld);
        push(OpLw, CNone, SDec, FNone);
        push(OpLw, CNone, SExec, FNone);
        push(OpLw, CRst, SMem, FDreq);
        push(OpLw, CNone, SIdle, FNone);
        push(OpAdd, CImem, SFetch, FImem | FIrld);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            drive_sample(e.stim, o);
            checks++;
            if (o !== e.obs) $display("FAIL rst_mem cyc %0d: got %h want %h", n, o, e.obs);
            else passed++;
            n++;
        end
        checks++;
        if (instr_count !== exp_cnt)
            $display("FAIL rst_mem count: got %0d want %0d", instr_count, exp_cnt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_muldiv();
        test_jump();
        test_halt();
        test_timeout_edge();
        test_timeout_err();
        test_wrap();
        test_rst_mem();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control sequencer for the 16-bit RISC core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with instruction memory, data memory and the iterative MUL/DIV unit. It emits the single-cycle enables (PC update, IR load, register write) that qualify the static decoder outputs. It sits between the opcode field of the IR and the datapath enables, and counts retired instructions.

Parameters:
TIMEOUT, 15, max consecutive wait cycles in FETCH, EXEC (MUL/DIV) or MEM before entering ERR (1..255)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
opcode  in  4  IR[15:12], valid from DECODE onward
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data memory access complete this cycle
alu_done  in  1  MUL/DIV result valid
halt_req  in  1  stop at next instruction boundary
imem_req  out  1  instruction fetch request, level
ir_load  out  1  latch instruction into IR, 1-cycle pulse
dmem_req  out  1  data memory request, level
dmem_we  out  1  write qualifier for dmem_req (SW)
alu_start  out  1  start MUL/DIV, 1-cycle pulse
wb_en  out  1  register-file write gate, 1-cycle pulse
pc_en  out  1  PC update/retire, 1-cycle pulse
halted  out  1  in HALT state
err  out  1  sticky timeout error
state  out  3  current state encoding
instr_count  out  CNT_W  retired instructions

Behaviour:
- Single clock domain. rst sampled on posedge clk dominates all other inputs. On reset: state=IDLE, every output 0, instr_count=0, wait counter=0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7. Outputs are Moore decodes of state except where noted.
- IDLE: go FETCH next cycle (HALT if halt_req=1).
- FETCH: imem_req=1. The cycle imem_ready=1: ir_load=1 (same cycle, combinational), next=DECODE. Zero-wait ready on the first FETCH cycle is legal.
- DECODE (1 cycle), by opcode:
  - 0000 NOP, 1010 J, 1011 JR: pc_en=1, next=boundary.
  - 0111 JAL: pc_en=1, wb_en=1 (link write), next=boundary.
  - All others: next=EXEC.
- EXEC:
  - 0011 MUL, 0110 DIV: alu_start=1 on the first EXEC cycle only. alu_done is ignored in that cycle and sampled from the second cycle on. When alu_done=1, next=WB.
  - 1100 LW, 1101 SW: 1 cycle, next=MEM.
  - Others: 1 cycle, next=WB.
- MEM: dmem_req=1 and dmem_we=(opcode==1101), held until dmem_ready=1. On ready:
  - SW: pc_en=1, next=boundary.
  - LW: next=WB.
- WB (1 cycle): wb_en=1, pc_en=1, next=boundary.
- Boundary: next=HALT if halt_req=1 in that cycle, else FETCH. halt_req is never honoured mid-instruction.
- HALT: halted=1. Go FETCH in the cycle after halt_req is sampled 0.
- Timeout: the wait counter clears on every state change. It increments in FETCH, MEM and multi-cycle EXEC while the awaited ready/done is 0. If it reaches TIMEOUT and the awaited signal is still 0, next=ERR. A ready arriving in that same cycle wins.
- ERR: err=1, all other outputs 0. The state is absorbing until rst.
- instr_count increments on every pc_en pulse and wraps from 2^CNT_W-1 to 0.
- Latency with zero-wait memories:
  - ALU ops, LI, CMP, MOV, SGT, ADDI: 4 cycles.
  - J/JR/JAL/NOP: 2 cycles.
  - SW: 4 cycles. LW: 5 cycles.
  - MUL/DIV: 4+N cycles, where N = extra cycles until alu_done.
- At most one of ir_load, alu_start, pc_en+wb_en groups is active per cycle. pc_en and wb_en never exceed 1 cycle per instruction.
- Opcode is treated as stable from DECODE until the next FETCH. Changes outside that window are ignored.

Test Plan:
- Reset, then ADD (0001) with imem_ready=1 tied high → state 0,1,2,3,5,1; ir_load in cycle 2 after rst release; wb_en=pc_en=1 in the WB cycle only; instr_count=1.
- LW (1100), dmem_ready delayed 3 cycles → dmem_req high for 4 cycles with dmem_we=0; then WB with wb_en=1; total 8 cycles FETCH→FETCH. SW (1101) zero-wait → dmem_we=1, pc_en in MEM, no wb_en.
- DIV (0110) with alu_done after 5 cycles → alu_start exactly 1 pulse; EXEC lasts 6 cycles; alu_done held high during the start cycle is ignored.
- JAL (0111) → pc_en=wb_en=1 in DECODE, back to FETCH. J (1010) → pc_en only. Assert halt_req mid-LW → LW completes, then HALT with halted=1; release → FETCH next cycle.
- TIMEOUT=15, imem_ready=0 forever → ERR entered after 16 FETCH cycles, err=1 sticky. Then rst → IDLE, err=0, instr_count=0.
- Preload instr_count=0xFFFF via 65535 NOPs, one more NOP → wraps to 0x0000. rst asserted in MEM → next cycle IDLE, dmem_req=0.
